// File: rtl/mem_stage_if.sv
// Execute-to-memory bundle, data-memory req/gnt/rvalid bus and write-back bundle of the memory stage.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface mem_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] opr_res;
    logic [DATA_WIDTH-1:0] opr_b;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] pc4;
    logic                  rf_en;
    logic                  dm_en;
    logic [1:0]            wb_sel;
    logic [2:0]            lsuop;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic                  wb_rf_en;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  misalign;

    modport slave (
        input  in_valid, opr_res, opr_b, rd, pc4, rf_en, dm_en, wb_sel, lsuop,
        output in_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output wb_valid, wb_rd, wb_rf_en, wb_data, misalign
    );

    modport master (
        output in_valid, opr_res, opr_b, rd, pc4, rf_en, dm_en, wb_sel, lsuop,
        input  in_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  wb_valid, wb_rd, wb_rf_en, wb_data, misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: aligns stores, extracts/extends loads, registers write-back. Latency 1 (ALU/misalign),
// 2+gnt wait (store), 3+gnt+rvalid wait (load); in_ready is low while a bus access is outstanding.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_lsuop;
    logic [1:0]            r_off;
    logic [4:0]            r_pend_rd;
    logic                  r_pend_rf_en;
    logic                  r_wb_valid;
    logic [4:0]            r_wb_rd;
    logic                  r_wb_rf_en;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_misalign;

    logic                  w_is_mem;
    logic                  w_legal;
    logic                  w_bad;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_alu_data;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_is_mem   = bus.dm_en || (bus.wb_sel == 2'b01);
    assign w_off      = bus.opr_res[1:0];
    assign w_alu_data = (bus.wb_sel == 2'b10) ? bus.pc4 : bus.opr_res;
    assign w_legal    = (bus.lsuop == LSU_B) || (bus.lsuop == LSU_H) || (bus.lsuop == LSU_W) ||
                        (bus.lsuop == LSU_BU) || (bus.lsuop == LSU_HU);
    assign w_bad      = !w_legal ||
                        ((bus.lsuop[1:0] == 2'b01) && w_off[0]) ||
                        ((bus.lsuop[1:0] == 2'b10) && (w_off != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.opr_b;
        case (bus.lsuop[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.opr_b[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.opr_b[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the offset captured at acceptance, since opr_res may change upstream.
    always_comb begin
        w_byte = bus.dmem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            2'd3:    w_byte = bus.dmem_rdata[31:24];
            default: ;
        endcase
        w_half      = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        w_load_data = bus.dmem_rdata;
        case (r_lsuop)
            LSU_B:   w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LSU_H:   w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LSU_BU:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LSU_HU:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_lsuop      <= '0;
            r_off        <= '0;
            r_pend_rd    <= '0;
            r_pend_rf_en <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_rf_en   <= 1'b0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= bus.rd;
                            r_wb_rf_en <= bus.rf_en;
                            r_wb_data  <= w_alu_data;
                        end else if (w_bad) begin
                            r_wb_valid <= 1'b1;
                            r_misalign <= 1'b1;
                            r_wb_rd    <= bus.rd;
                            r_wb_rf_en <= 1'b0;
                            r_wb_data  <= '0;
                        end else begin
                            r_req        <= 1'b1;
                            r_we         <= bus.dm_en;
                            r_addr       <= {bus.opr_res[ADDR_WIDTH-1:2], 2'b00};
                            r_be         <= w_be;
                            r_wdata      <= w_wdata;
                            r_lsuop      <= bus.lsuop;
                            r_off        <= w_off;
                            r_pend_rd    <= bus.rd;
                            // A store only writes the register file when it also claims the MEM select.
                            r_pend_rf_en <= bus.dm_en ? (bus.rf_en && (bus.wb_sel == 2'b01)) : bus.rf_en;
                            r_in_ready   <= 1'b0;
                            r_state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_pend_rd;
                            r_wb_rf_en <= r_pend_rf_en;
                            r_wb_data  <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.dmem_rvalid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_pend_rd;
                        r_wb_rf_en <= r_pend_rf_en;
                        r_wb_data  <= w_load_data;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_be    = r_be;
    assign bus.dmem_wdata = r_wdata;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.wb_rf_en   = r_wb_rf_en;
    assign bus.wb_data    = r_wb_data;
    assign bus.misalign   = r_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver predicts each retirement from a behavioural model,
// a memory responder and a write-back monitor compare independently.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_at = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_if bus ();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic        rf;
        logic [31:0] data;
        bit          chk_data;
        logic        mis;
        int          cyc;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gd;
        int          rdl;
        logic [31:0] rdata;
    } mem_t;

    wb_t  wb_q[$];
    mem_t mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model of the access rules.
    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] w;
        logic [31:0] v;
        w = rdata >> ((addr % 4) * 8);
        case (op)
            3'd0: begin v = w & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = w & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = w & 32'hFF;
            3'd5: v = w & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        int s;
        s = size_of(op);
        if (s == 1) return 4'(1 << (addr % 4));
        if (s == 2) return 4'(3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] b);
        int s;
        s = size_of(op);
        if (s == 1) return (b & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    task automatic issue(input logic [31:0] res, input logic [31:0] b, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rf, input logic dm, input logic [1:0] sel,
                         input logic [2:0] op, input int gd, input int rdl, input logic [31:0] rdata,
                         input bit use_lit, input logic [31:0] lit, input bit no_wb);
        wb_t  e;
        mem_t m;
        bit   is_mem;
        bit   bad;
        int   lat;
        int   t0;
        int   exp_acc;
        int   waited;
        is_mem = dm || (sel == 2'b01);
        bad    = (size_of(op) == 0) || ((res % size_of(op)) != 0);
        e.rd = rd; e.mis = 1'b0; e.chk_data = 1'b1; e.data = '0; e.rf = 1'b0; e.cyc = 0;
        m.we = 1'b0; m.addr = res - (res % 4); m.be = '0; m.wdata = '0;
        m.gd = gd; m.rdl = rdl; m.rdata = rdata;
        if (!is_mem) begin
            lat = 1; e.rf = rf; e.data = (sel == 2'b10) ? pc : res;
        end else if (bad) begin
            lat = 1; e.mis = 1'b1; e.chk_data = 1'b0;
        end else if (dm) begin
            lat = 2 + gd;
            e.rf = (sel == 2'b01) ? rf : 1'b0;
            e.chk_data = (sel == 2'b01);
            m.we = 1'b1; m.be = model_be(op, res); m.wdata = model_wdata(op, b);
        end else begin
            lat = 3 + gd + rdl; e.rf = rf; e.data = model_load(op, res, rdata);
        end
        if (use_lit) e.data = lit;
        t0 = cyc;
        exp_acc = (ready_at > t0) ? ready_at : t0;
        bus.opr_res = res; bus.opr_b = b; bus.pc4 = pc; bus.rd = rd; bus.rf_en = rf;
        bus.dm_en = dm; bus.wb_sel = sel; bus.lsuop = op; bus.in_valid = 1'b1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles, required 1", bus.in_ready, waited);
        end else begin
            check("accept_cycle", 32'(cyc), 32'(exp_acc));
            e.cyc = cyc + lat;
            if (!no_wb) wb_q.push_back(e);
            if (is_mem && !bad) mem_q.push_back(m);
            ready_at = cyc + ((is_mem && !bad) ? lat : 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Memory responder: grants after the scripted delay and checks the request it sees.
    bit   req_active = 0;
    bit   rv_pending = 0;
    bit   bogus = 0;
    int   gcnt = 0;
    int   rcnt = 0;
    int   req_cycles = 0;
    mem_t cur;

    initial begin
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.dmem_gnt = 1'b0;
            bus.dmem_rvalid = 1'b0;
            if (rv_pending) begin
                check("req_low_in_resp", 32'(bus.dmem_req), 32'd0);
                if (rcnt == 0) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata = cur.rdata;
                    rv_pending = 0;
                end else begin
                    rcnt--;
                end
            end else if (bus.dmem_req === 1'b1) begin
                if (!req_active) begin
                    bogus = (mem_q.size() == 0);
                    if (bogus) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_dmem_req: req=1 addr=0x%08h, required no request", bus.dmem_addr);
                        cur.gd = 0; cur.rdl = 0; cur.rdata = '0; cur.we = bus.dmem_we;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                    req_active = 1; gcnt = cur.gd; req_cycles = 0;
                end
                req_cycles++;
                if (!bogus) begin
                    check("dmem_addr", bus.dmem_addr, cur.addr);
                    check("dmem_we", 32'(bus.dmem_we), 32'(cur.we));
                    if (cur.we) begin
                        check("dmem_be", 32'(bus.dmem_be), 32'(cur.be));
                        check("dmem_wdata", bus.dmem_wdata, cur.wdata);
                    end
                end
                if (gcnt == 0) begin
                    bus.dmem_gnt = 1'b1;
                    req_active = 0;
                    if (!bogus) check("req_cycles", 32'(req_cycles), 32'(cur.gd + 1));
                    if (!cur.we) begin rv_pending = 1; rcnt = cur.rdl; end
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // Write-back monitor.
    wb_t e_mon;
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wb_unexpected: wb_valid=1 rd=%0d, required no retirement", bus.wb_rd);
            end else begin
                e_mon = wb_q.pop_front();
                check("wb_rd", 32'(bus.wb_rd), 32'(e_mon.rd));
                check("wb_rf_en", 32'(bus.wb_rf_en), 32'(e_mon.rf));
                check("misalign", 32'(bus.misalign), 32'(e_mon.mis));
                check("wb_cycle", 32'(cyc), 32'(e_mon.cyc));
                if (e_mon.chk_data) check("wb_data", bus.wb_data, e_mon.data);
            end
        end else if (bus.misalign !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL misalign_alone: misalign=%b without wb_valid, required 0", bus.misalign);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_dmem_req"}, 32'(bus.dmem_req), 32'd0);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "_misalign"}, 32'(bus.misalign), 32'd0);
        check({tag, "_wb_data"}, bus.wb_data, 32'd0);
        check({tag, "_dmem_be"}, 32'(bus.dmem_be), 32'd0);
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && wb_q.size() != 0; w++) @(negedge clk);
        check("drain_empty", 32'(wb_q.size()), 32'd0);
    endtask

    logic [2:0] legal_ops[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] r_res;
    logic [2:0]  r_op;
    logic [1:0]  r_sel;
    logic        r_dm;
    int          kind;
    int          wb_seen;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.opr_res = '0; bus.opr_b = '0; bus.pc4 = '0; bus.rd = '0;
        bus.rf_en = 1'b0; bus.dm_en = 1'b0; bus.wb_sel = '0; bus.lsuop = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        ready_at = cyc + 1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        issue(32'h0000_1234, 32'h0, 32'h40, 5'd5, 1'b1, 1'b0, 2'b00, 3'd2, 0, 0, 32'h0, 1, 32'h0000_1234, 0);
        issue(32'h0000_0103, 32'hAABB_CCDD, 32'h0, 5'd7, 1'b0, 1'b1, 2'b00, 3'd0, 2, 0, 32'h0, 0, 32'h0, 0);
        issue(32'h0000_0102, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 3'd0, 0, 0, 32'h0080_0000, 1, 32'hFFFF_FF80, 0);
        issue(32'h0000_0102, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 2'b01, 3'd4, 0, 0, 32'h0080_0000, 1, 32'h0000_0080, 0);
        issue(32'h0000_0102, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 2'b01, 3'd5, 0, 1, 32'hBEEF_0000, 1, 32'h0000_BEEF, 0);
        issue(32'h0000_0102, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 2'b01, 3'd1, 1, 0, 32'hBEEF_0000, 1, 32'hFFFF_BEEF, 0);
        issue(32'h0000_0101, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 2'b01, 3'd2, 0, 0, 32'h0, 0, 32'h0, 0);
        issue(32'h0000_0200, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 2'b01, 3'd3, 0, 0, 32'h0, 0, 32'h0, 0);
        issue(32'h0000_0204, 32'h1122_3344, 32'h0, 5'd14, 1'b1, 1'b1, 2'b01, 3'd2, 1, 0, 32'h0, 1, 32'h0, 0);
        issue(32'h0000_0300, 32'h0, 32'h0000_0088, 5'd15, 1'b1, 1'b0, 2'b10, 3'd2, 0, 0, 32'h0, 1, 32'h0000_0088, 0);
        issue(32'h0000_0011, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 2'b00, 3'd0, 0, 0, 32'h0, 1, 32'h0000_0011, 0);
        issue(32'h0000_0400, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 2'b01, 3'd2, 0, 3, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0);
        issue(32'h0000_0022, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 2'b11, 3'd0, 0, 0, 32'h0, 1, 32'h0000_0022, 0);
        drain();

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 2));
            r_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_ops[$urandom_range(0, 4)];
            r_res = $urandom;
            if ($urandom_range(0, 1) == 1) r_res = r_res & ~32'h3;
            if (kind == 0) begin
                r_dm = 1'b0;
                r_sel = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            end else if (kind == 1) begin
                r_dm = 1'b0; r_sel = 2'b01;
            end else begin
                r_dm = 1'b1; r_sel = 2'($urandom_range(0, 3));
            end
            issue(r_res, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  r_dm, r_sel, r_op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  $urandom, 0, 32'h0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        issue(32'h0000_0500, 32'h0, 32'h0, 5'd20, 1'b1, 1'b0, 2'b01, 3'd2, 0, 8, 32'h1234_5678, 0, 32'h0, 1);
        @(negedge clk);
        check("in_ready_in_resp", 32'(bus.in_ready), 32'd0);
        check("req_low_before_rst", 32'(bus.dmem_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        ready_at = cyc + 1;
        wb_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) wb_seen++;
        end
        check("no_wb_after_rst", 32'(wb_seen), 32'd0);
        issue(32'h0000_0077, 32'h0, 32'h0, 5'd21, 1'b1, 1'b0, 2'b00, 3'd2, 0, 0, 32'h0, 1, 32'h0000_0077, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
